// File: rtl/nibbler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nibbler_pkg
//  Description : Shared definitions for the Nibbler CPU sequencer: control
//                word width, control field bit positions and the sequencer
//                state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package nibbler_pkg;

    // Control word layout, MSB first:
    // incPC, loadPC, loadA, loadFlags, csRAM, weRAM, oeALU, oeIn, oeOprnd, loadOut
    localparam int CTRL_W         = 10;
    localparam int CTRL_INCPC     = 9;
    localparam int CTRL_LOADPC    = 8;
    localparam int CTRL_LOADA     = 7;
    localparam int CTRL_LOADFLAGS = 6;
    localparam int CTRL_CSRAM     = 5;
    localparam int CTRL_WERAM     = 4;
    localparam int CTRL_OEALU     = 3;
    localparam int CTRL_OEIN      = 2;
    localparam int CTRL_OEOPRND   = 1;
    localparam int CTRL_LOADOUT   = 0;

    // During FETCH only the PC increment may reach the datapath.
    localparam logic [CTRL_W-1:0] CTRL_FETCH_MASK =
        {{(CTRL_W-1){1'b0}}, 1'b1} << CTRL_INCPC;

    typedef enum logic [2:0] {
        ST_STOP     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_EXEC     = 3'd2,
        ST_WAIT_IN  = 3'd3,
        ST_WAIT_OUT = 3'd4
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/nibble_sequencer_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module      : wait_timer
//  Description : Handshake wait counter. Cleared by i_clear, counts up by one
//                per cycle while i_enable is high, and flags o_expired once
//                the count reaches WAIT_MAX (holding there).
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                i_clear         - return count to zero (wins over enable)
//                i_enable        - count this cycle
//                o_expired       - count equals WAIT_MAX
//  Revision    : 1.0 - initial release
// ============================================================================
module wait_timer #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    // A zero-width counter is illegal, so keep at least one bit.
    localparam int c_cnt_w = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [c_cnt_w-1:0] c_wait_max = c_cnt_w'(WAIT_MAX);
    localparam logic [c_cnt_w-1:0] c_one      = c_cnt_w'(1);

    logic [c_cnt_w-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + c_one;
        end
    end

    assign o_expired = (r_count == c_wait_max);

endmodule
`default_nettype wire

// File: rtl/nibble_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_sequencer
//  Description : Fetch/execute sequencer for the Nibbler CPU. Provides
//                run/single-step control, stalls execute on the input and
//                output port handshakes, and gates the decode control word so
//                that PC, registers and RAM only change in the legal cycle.
//                A handshake that stays absent for more than WAIT_MAX wait
//                cycles raises a sticky timeout and stops the machine.
//  Ports       : clk, reset            - clock, synchronous active-high reset
//                run, step             - free-run level / single-step pulse
//                ctrl_in, ctrl_out     - decode control word in / gated out
//                fetch_en, phase       - Fetch load enable / phase to decode
//                in_valid, in_ready    - input-port handshake
//                out_valid, out_ready  - output-port handshake
//                halted, timeout       - in STOP / sticky handshake fault
//  Revision    : 1.0 - initial release
// ============================================================================
module nibble_sequencer
    import nibbler_pkg::*;
#(
    parameter int WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              step,
    input  logic [CTRL_W-1:0] ctrl_in,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic              fetch_en,
    output logic              phase,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              halted,
    output logic              timeout
);

    seq_state_t r_state;
    logic       r_timeout;

    logic       w_oe_in;
    logic       w_load_out;
    logic       w_in_stall;
    logic       w_waiting;
    logic       w_timer_clear;
    logic       w_expired;
    seq_state_t w_end_state;

    assign w_oe_in    = ctrl_in[CTRL_OEIN];
    assign w_load_out = ctrl_in[CTRL_LOADOUT];
    assign w_in_stall = w_oe_in && !in_valid;

    // Where an instruction goes once it completes: continue or park.
    assign w_end_state = run ? ST_FETCH : ST_STOP;

    // The counter runs only in the two wait states. Holding it clear in every
    // other state means it always starts from zero on entry; the extra clear
    // on an input handshake covers the direct WAIT_IN -> WAIT_OUT hop.
    assign w_waiting     = (r_state == ST_WAIT_IN) || (r_state == ST_WAIT_OUT);
    assign w_timer_clear = !w_waiting || ((r_state == ST_WAIT_IN) && in_valid);

    wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk       (clk),
        .rst       (reset),
        .i_clear   (w_timer_clear),
        .i_enable  (w_waiting),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_STOP;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                ST_STOP: begin
                    if ((run || step) && !r_timeout) begin
                        r_state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (w_in_stall) begin
                        r_state <= ST_WAIT_IN;
                    end else if (w_load_out) begin
                        r_state <= ST_WAIT_OUT;
                    end else begin
                        r_state <= w_end_state;
                    end
                end
                ST_WAIT_IN: begin
                    if (in_valid) begin
                        r_state <= w_load_out ? ST_WAIT_OUT : w_end_state;
                    end else if (w_expired) begin
                        r_timeout <= 1'b1;
                        r_state   <= ST_STOP;
                    end
                end
                ST_WAIT_OUT: begin
                    if (out_ready) begin
                        r_state <= w_end_state;
                    end else if (w_expired) begin
                        r_timeout <= 1'b1;
                        r_state   <= ST_STOP;
                    end
                end
                default: begin
                    r_state <= ST_STOP;
                end
            endcase
        end
    end

    // Outputs are decoded from the current state and live inputs so that a
    // handshake is accepted in the very cycle it is presented.
    always_comb begin
        ctrl_out  = '0;
        fetch_en  = 1'b0;
        phase     = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            ST_FETCH: begin
                fetch_en = 1'b1;
                ctrl_out = ctrl_in & CTRL_FETCH_MASK;
            end
            ST_EXEC: begin
                phase = 1'b1;
                if (!w_in_stall) begin
                    ctrl_out = ctrl_in;
                    in_ready = w_oe_in;
                end
            end
            ST_WAIT_IN: begin
                phase = 1'b1;
                if (in_valid) begin
                    ctrl_out = ctrl_in;
                    in_ready = 1'b1;
                end
            end
            ST_WAIT_OUT: begin
                phase     = 1'b1;
                out_valid = 1'b1;
            end
            default: begin
                ctrl_out = '0;
            end
        endcase
    end

    assign halted  = (r_state == ST_STOP);
    assign timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_nibble_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nibble_sequencer
//  Description : Self-checking bench for nibble_sequencer. A driver expands
//                each instruction (control word, input delay, output delay)
//                into the per-cycle behaviour required of the sequencer and
//                queues the expected outputs; a monitor compares the DUT
//                outputs against the queue on every falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_sequencer;

    localparam int   WAIT_MAX = 3;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic       clk       = 1'b0;
    logic       reset     = 1'b1;
    logic       run       = 1'b0;
    logic       step      = 1'b0;
    logic       in_valid  = 1'b0;
    logic       out_ready = 1'b0;
    logic [9:0] ctrl_in   = '0;
    logic [9:0] ctrl_out;
    logic       fetch_en, phase, in_ready, out_valid, halted, timeout;

    always #5 clk = ~clk;

    nibble_sequencer #(
        .WAIT_MAX (WAIT_MAX)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .step      (step),
        .ctrl_in   (ctrl_in),
        .ctrl_out  (ctrl_out),
        .fetch_en  (fetch_en),
        .phase     (phase),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .halted    (halted),
        .timeout   (timeout)
    );

    typedef struct packed {
        logic [9:0] ctrl;
        logic       fe;
        logic       ph;
        logic       ir;
        logic       ov;
        logic       hl;
        logic       to;
    } obs_t;

    obs_t  exp_q[$];
    string tag_q[$];
    int    compared   = 0;
    int    mismatched = 0;

    // Driver bookkeeping for the instruction being expanded.
    int    idx;
    int    reset_at;
    logic  aborted;
    logic  step_mode;
    logic  force_step;
    logic  run_end;
    string cur_tag;
    logic  in_stop;
    logic  to_flag;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic obs_t mk(input logic [9:0] c, input logic fe, input logic ph,
                                input logic ir, input logic ov, input logic hl,
                                input logic to);
        obs_t o;
        o.ctrl = c;
        o.fe   = fe;
        o.ph   = ph;
        o.ir   = ir;
        o.ov   = ov;
        o.hl   = hl;
        o.to   = to;
        return o;
    endfunction

    // Apply one cycle of inputs just after the rising edge and queue what the
    // outputs must look like during that cycle.
    task automatic drive(input logic [9:0] cin, input logic r, input logic s,
                         input logic iv, input logic ordy, input logic rs,
                         input obs_t e);
        @(posedge clk);
        #1;
        ctrl_in   = cin;
        run       = r;
        step      = s;
        in_valid  = iv;
        out_ready = ordy;
        reset     = rs;
        exp_q.push_back(e);
        tag_q.push_back(cur_tag);
    endtask

    // One cycle inside an instruction; 'last' marks the completing cycle,
    // the only one where run decides between FETCH and STOP.
    task automatic emit(input logic [9:0] cin, input logic last, input logic iv,
                        input logic ordy, input obs_t e);
        logic r, s, rs;
        r  = last ? run_end : (step_mode ? L : rb());
        s  = force_step ? H : rb();
        rs = (idx == reset_at);
        drive(cin, r, s, iv, ordy, rs, e);
        if (rs) aborted = H;
        idx++;
    endtask

    // Reference behaviour of one instruction starting at FETCH.
    // n: cycles in_valid stays low from the execute cycle (input instrs)
    // m: cycles out_ready stays low once out_valid is raised (output instrs)
    task automatic do_instr(input logic [9:0] w, input int n, input int m,
                            output logic tmo);
        logic oe, lo;
        obs_t stall;
        oe    = w[2];
        lo    = w[0];
        tmo   = L;
        stall = mk('0, L, H, L, L, L, L);
        emit(w, L, rb(), rb(), mk({w[9], 9'b0}, H, L, L, L, L, L));
        if (aborted) return;
        if (oe && n > 0) begin
            emit(w, L, L, rb(), stall);
            if (aborted) return;
            for (int k = 0; k < n; k++) begin
                if (k == n - 1) begin
                    emit(w, !lo, H, rb(), mk(w, L, H, H, L, L, L));
                    if (aborted) return;
                end else begin
                    emit(w, L, L, rb(), stall);
                    if (aborted) return;
                    if (k == WAIT_MAX) begin
                        tmo = H;
                        return;
                    end
                end
            end
        end else begin
            emit(w, !lo, oe ? H : rb(), rb(), mk(w, L, H, oe, L, L, L));
            if (aborted) return;
        end
        if (lo) begin
            for (int j = 0; j <= m; j++) begin
                if (j == m) begin
                    emit(w, H, rb(), H, mk('0, L, H, L, H, L, L));
                end else begin
                    emit(w, L, rb(), L, mk('0, L, H, L, H, L, L));
                    if (aborted) return;
                    if (j == WAIT_MAX) begin
                        tmo = H;
                        return;
                    end
                end
            end
        end
    endtask

    task automatic instr(input string tag, input logic [9:0] w, input int n,
                         input int m, input logic smode, input logic rend,
                         input logic fstep, input int rst_at);
        logic tmo;
        cur_tag = tag;
        if (to_flag) begin
            // Faulted: run and step must have no effect until reset.
            for (int i = 0; i < 2; i++) begin
                drive(w, H, H, rb(), rb(), L, mk('0, L, L, L, L, H, H));
            end
            drive(w, H, H, L, L, H, mk('0, L, L, L, L, H, H));
            to_flag = L;
            in_stop = H;
        end
        if (in_stop) begin
            for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
                drive(w, L, L, rb(), rb(), L, mk('0, L, L, L, L, H, L));
            end
            drive(w, !smode, smode, rb(), rb(), L, mk('0, L, L, L, L, H, L));
        end
        step_mode  = smode;
        force_step = fstep;
        run_end    = smode ? L : rend;
        reset_at   = rst_at;
        idx        = 0;
        aborted    = L;
        do_instr(w, n, m, tmo);
        if (aborted) begin
            in_stop = H;
            to_flag = L;
        end else if (tmo) begin
            in_stop = H;
            to_flag = H;
        end else begin
            in_stop = !run_end;
        end
    endtask

    always @(negedge clk) begin : monitor
        obs_t  e;
        obs_t  a;
        string t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a = {ctrl_out, fetch_en, phase, in_ready, out_valid, halted, timeout};
            compared++;
            if (a !== e) begin
                mismatched++;
                $display("FAIL %s @%0t: got ctrl=%b fe=%b ph=%b ir=%b ov=%b hlt=%b to=%b, want ctrl=%b fe=%b ph=%b ir=%b ov=%b hlt=%b to=%b",
                         t, $time, a.ctrl, a.fe, a.ph, a.ir, a.ov, a.hl, a.to,
                         e.ctrl, e.fe, e.ph, e.ir, e.ov, e.hl, e.to);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : driver
        logic [9:0] w;
        int         n, m, ra;
        logic       sm;

        step_mode  = L;
        force_step = L;
        run_end    = L;
        reset_at   = -1;
        idx        = 0;
        aborted    = L;
        cur_tag    = "reset";
        in_stop    = H;
        to_flag    = L;

        drive('0, L, L, L, L, H, mk('0, L, L, L, L, H, L));
        drive('0, H, H, H, H, H, mk('0, L, L, L, L, H, L));

        for (int i = 0; i < 3; i++) begin
            instr("alu_run", 10'b10_0110_1000, 0, 0, L, H, L, -1);
        end
        instr("input_wait", 10'b00_1000_0100, 4, 0, L, H, L, -1);
        instr("output_wait", 10'b00_0000_0001, 0, 2, L, L, L, -1);
        instr("step", 10'b10_0010_1000, 0, 0, H, L, H, -1);
        instr("step_again", 10'b00_0100_1000, 0, 0, H, L, L, -1);
        instr("timeout_in", 10'b00_0000_0100, 7, 0, L, H, L, -1);
        instr("reset_wait_out", 10'b00_0000_0001, 0, 5, L, H, L, 3);
        instr("timeout_out", 10'b00_0000_0001, 0, 5, L, H, L, -1);

        for (int t = 0; t < 80; t++) begin
            w  = 10'($urandom);
            n  = $urandom_range(0, 6);
            m  = $urandom_range(0, 5);
            sm = in_stop && ($urandom_range(0, 3) == 0);
            ra = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 5)) : -1;
            instr("random", w, n, m, sm, rb(), L, ra);
        end

        repeat (2) @(negedge clk);
        #1;
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d expected cycles left unchecked, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
